// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types, constants and suppression helper for the seven-segment scanner
package seg_pkg;

    localparam int unsigned MAX_DIGITS = 8;

    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } seg_state_e;

    // Bit i set means digit i is a leading zero to hide: every nibble from i
    // up to the most significant digit is zero. Digit 0 always stays visible.
    function automatic logic [MAX_DIGITS-1:0] lz_suppress_mask(
        input logic [4*MAX_DIGITS-1:0] nibbles,
        input int unsigned             n_digits,
        input logic                    lz_en
    );
        logic [MAX_DIGITS-1:0] mask;
        logic                  seen_nonzero;
        mask         = '0;
        seen_nonzero = 1'b0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (i < int'(n_digits)) begin
                seen_nonzero = seen_nonzero | (nibbles[i*4 +: 4] != 4'h0);
                mask[i]      = lz_en & (i != 0) & ~seen_nonzero;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/seg_prescaler.sv
// rtl/seg_prescaler.sv - terminal-count divider with sync clear and wrap pulse
module seg_prescaler #(
    parameter int unsigned DIV = 50000,
    parameter int unsigned W   = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_next_o,
    output logic         wrap_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins, otherwise count up and wrap at terminal count.
    always_comb begin
        count_d = count_q;
        wrap_o  = 1'b0;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            if (count_q == W'(DIV - 1)) begin
                count_d = '0;
                wrap_o  = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_next_o = count_d;

endmodule

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - time-multiplexed digit scanner for a common-anode display bank
module seven_seg_scanner
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    lz_blank,
    output logic [3:0]              digit_value,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    dp_n,
    output logic                    frame_start
);

    localparam int unsigned IW = $clog2(NUM_DIGITS);
    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    seg_state_e              state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
    logic [4*NUM_DIGITS-1:0] frame_q, frame_d;
    logic [3:0]              dv_q, dv_d;
    logic [NUM_DIGITS-1:0]   an_int_q, an_int_d;
    logic                    dp_int_q, dp_int_d;
    logic [NUM_DIGITS-1:0]   an_q;
    logic                    dp_q;
    logic                    fs_q, fs_d;

    logic [PW-1:0]           presc_next;
    logic                    presc_wrap;
    logic                    presc_clr;
    logic                    boundary;
    logic                    lit;
    logic [MAX_DIGITS-1:0]   supp;

    // The prescaler only runs while scanning; IDLE pins it at 0 so the
    // first BLANK cycle after enable starts a fresh slot.
    assign presc_clr = ~enable | (state_q == ST_IDLE);

    seg_prescaler #(
        .DIV (REFRESH_DIV),
        .W   (PW)
    ) u_prescaler (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (presc_clr),
        .en_i         (1'b1),
        .count_next_o (presc_next),
        .wrap_o       (presc_wrap)
    );

    // Next state, digit index, frame latch and first-stage outputs, all
    // computed from next-state values so they land on the same edge.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        frame_d  = frame_q;
        pend_d   = load ? value : pend_q;
        boundary = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else if (state_q == ST_IDLE) begin
            state_d  = ST_BLANK;
            idx_d    = '0;
            boundary = 1'b1;
        end else begin
            if (presc_wrap) begin
                if (idx_q == IW'(NUM_DIGITS - 1)) begin
                    idx_d    = '0;
                    boundary = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            state_d = (presc_next < PW'(BLANK_CYCLES)) ? ST_BLANK : ST_DRIVE;
        end

        // pend_d already folds in a same-cycle load, so it reaches the frame.
        if (boundary) begin
            frame_d = pend_d;
        end

        supp     = lz_suppress_mask(32'(frame_d), NUM_DIGITS, lz_blank);
        lit      = (state_d == ST_DRIVE) & ~supp[idx_d];
        an_int_d = ANODE_OFF[NUM_DIGITS-1:0];
        if (lit) begin
            an_int_d[idx_d] = 1'b0;
        end
        dp_int_d = ~(lit & dp_mask[idx_d]);
        dv_d     = frame_d[idx_d*4 +: 4];
        fs_d     = (state_d != ST_IDLE) & (idx_d == '0) & (presc_next == '0);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; anode/dp get a second stage to match the decoder delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            pend_q   <= '0;
            frame_q  <= '0;
            dv_q     <= '0;
            an_int_q <= ANODE_OFF[NUM_DIGITS-1:0];
            dp_int_q <= 1'b1;
            an_q     <= ANODE_OFF[NUM_DIGITS-1:0];
            dp_q     <= 1'b1;
            fs_q     <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            frame_q  <= frame_d;
            dv_q     <= dv_d;
            an_int_q <= an_int_d;
            dp_int_q <= dp_int_d;
            an_q     <= an_int_q;
            dp_q     <= dp_int_q;
            fs_q     <= fs_d;
        end
    end

    assign digit_value = dv_q;
    assign an_n        = an_q;
    assign dp_n        = dp_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - randomized self-checking bench for seven_seg_scanner
module tb_seven_seg_scanner;

    localparam int N  = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FP = N * RD;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [4*N-1:0] value = '0;
    logic          load = 1'b0;
    logic [N-1:0]  dp_mask = '0;
    logic          lz_blank = 1'b0;
    logic [3:0]    digit_value;
    logic [N-1:0]  an_n;
    logic          dp_n;
    logic          frame_start;

    int passed = 0;
    int total  = 0;

    seven_seg_scanner #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .value       (value),
        .load        (load),
        .dp_mask     (dp_mask),
        .lz_blank    (lz_blank),
        .digit_value (digit_value),
        .an_n        (an_n),
        .dp_n        (dp_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: position within the frame, -1 when not scanning.
    int          pos;
    int          np;
    int          slot;
    bit          drive_m;
    logic [15:0] m_pend, m_frame;
    logic [3:0]  m_dv;
    logic [N-1:0] s1_an, m_an;
    logic        s1_dp, m_dp, m_fs;

    function automatic bit m_supp(input logic [15:0] f, input int d, input bit lz);
        int hi = -1;
        for (int i = 0; i < N; i++) if (f[i*4 +: 4] != 4'h0) hi = i;
        return lz && d > 0 && d > hi;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos = -1; m_pend = '0; m_frame = '0; m_dv = '0;
            s1_an = '1; s1_dp = 1'b1; m_an = '1; m_dp = 1'b1; m_fs = 1'b0;
        end else begin
            np = !enable ? -1 : (pos < 0 ? 0 : (pos + 1) % FP);
            if (np == 0) m_frame = load ? value : m_pend;
            if (load) m_pend = value;
            pos  = np;
            m_an = s1_an;
            m_dp = s1_dp;
            slot = (np < 0) ? 0 : np / RD;
            m_dv = m_frame[slot*4 +: 4];
            drive_m = (np >= 0) && ((np % RD) >= BC) && !m_supp(m_frame, slot, lz_blank);
            s1_an = drive_m ? ~(N'(1) << slot) : '1;
            s1_dp = !(drive_m && dp_mask[slot]);
            m_fs  = (np == 0);
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("m_digit_value", 32'(digit_value), 32'(m_dv));
        chk("m_an_n", 32'(an_n), 32'(m_an));
        chk("m_dp_n", 32'(dp_n), 32'(m_dp));
        chk("m_frame_start", 32'(frame_start), 32'(m_fs));
    end

    task automatic wait_fs(input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!frame_start && cycles < budget);
        chk("frame_start_seen", 32'(frame_start), 32'd1);
    endtask

    task automatic load_val(input logic [15:0] v);
        value = v; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    int c;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_dv", 32'(digit_value), 32'd0);
        chk("rst_an", 32'(an_n), 32'hF);
        chk("rst_dp", 32'(dp_n), 32'd1);
        chk("rst_fs", 32'(frame_start), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic scan of 1234.
        load_val(16'h1234);
        enable = 1'b1;
        wait_fs(8, c);
        chk("t1_first_latency", 32'(c), 32'd1);
        chk("t1_dv0", 32'(digit_value), 32'h4);
        repeat (3) @(negedge clk);
        chk("t1_an0", 32'(an_n), 32'hE);
        repeat (5) @(negedge clk);
        chk("t1_dv1", 32'(digit_value), 32'h3);
        chk("t1_an_lag", 32'(an_n), 32'hE);
        @(negedge clk);
        chk("t1_an_blank", 32'(an_n), 32'hF);
        repeat (2) @(negedge clk);
        chk("t1_an1", 32'(an_n), 32'hD);
        wait_fs(40, c);
        chk("t1_rest", 32'(c), 32'd21);

        // Mid-frame load must not tear the displayed frame.
        repeat (10) @(negedge clk);
        load_val(16'hABCD);
        repeat (5) @(negedge clk);
        chk("t3_dv2", 32'(digit_value), 32'h2);
        repeat (8) @(negedge clk);
        chk("t3_dv3", 32'(digit_value), 32'h1);
        wait_fs(40, c);
        chk("t3_rest", 32'(c), 32'd8);
        chk("t3_new0", 32'(digit_value), 32'hD);
        repeat (8) @(negedge clk);
        chk("t3_new1", 32'(digit_value), 32'hC);

        // Leading-zero blanking of 0050.
        lz_blank = 1'b1;
        load_val(16'h0050);
        wait_fs(40, c);
        repeat (3) @(negedge clk);
        chk("t2_an0", 32'(an_n), 32'hE);
        repeat (5) @(negedge clk);
        chk("t2_dv1", 32'(digit_value), 32'h5);
        repeat (3) @(negedge clk);
        chk("t2_an1", 32'(an_n), 32'hD);
        repeat (8) @(negedge clk);
        chk("t2_an2", 32'(an_n), 32'hF);
        repeat (8) @(negedge clk);
        chk("t2_an3", 32'(an_n), 32'hF);
        wait_fs(40, c);
        chk("t2_rest", 32'(c), 32'd5);
        wait_fs(40, c);
        chk("t2_period", 32'(c), 32'd32);

        // Decimal point on a suppressed digit, then on a driven one.
        dp_mask = 4'b0100;
        load_val(16'h0000);
        wait_fs(40, c);
        repeat (19) @(negedge clk);
        chk("t4_dp_supp", 32'(dp_n), 32'd1);
        chk("t4_an_supp", 32'(an_n), 32'hF);
        lz_blank = 1'b0;
        wait_fs(40, c);
        repeat (19) @(negedge clk);
        chk("t4_dp_on", 32'(dp_n), 32'd0);
        chk("t4_an_on", 32'(an_n), 32'hB);
        repeat (6) @(negedge clk);
        chk("t4_dp_off", 32'(dp_n), 32'd1);

        // Enable dropped mid-drive, then restart.
        wait_fs(40, c);
        repeat (4) @(negedge clk);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_an_off", 32'(an_n), 32'hF);
        repeat (3) @(negedge clk);
        enable = 1'b1;
        wait_fs(4, c);
        chk("t5_restart", 32'(c), 32'd1);

        // Asynchronous reset mid-slot.
        load_val(16'h9876);
        wait_fs(40, c);
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_an_async", 32'(an_n), 32'hF);
        chk("t6_dp_async", 32'(dp_n), 32'd1);
        chk("t6_dv_async", 32'(digit_value), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_fs(4, c);
        chk("t6_restart", 32'(c), 32'd1);
        chk("t6_frame_zero", 32'(digit_value), 32'd0);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            load = ($urandom_range(0, 11) == 0);
            for (int d = 0; d < N; d++)
                value[d*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            dp_mask = N'($urandom);
            if ($urandom_range(0, 63) == 0) lz_blank = ~lz_blank;
            if ($urandom_range(0, 149) == 0) enable = ~enable;
        end
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
